// File: rtl/lfsr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl_if
// Brief    : Two-requester request bus and single response bus of lfsr_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_seq_ctrl_if #(
    parameter int N     = 26,
    parameter int CNT_W = 8
) ();
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_seed;
    logic [3:0]       req1_seed;
    logic [CNT_W-1:0] req0_steps;
    logic [CNT_W-1:0] req1_steps;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [N-1:0]     rsp_data;

    modport master (
        output req_valid, req0_seed, req1_seed, req0_steps, req1_steps, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req0_seed, req1_seed, req0_steps, req1_steps, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl
// Brief    : Arbitrates two requesters, seeds an external LFSR, advances it a
//            requested number of steps and returns the captured state.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int N     = 26,
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    lfsr_seq_ctrl_if.slave    bus,
    output logic [N-1:0]      lfsr_s,
    output logic              lfsr_r,
    input  wire logic [N-1:0] lfsr_q,
    output logic              busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_seed;
    logic             r_id;
    logic             r_last_gnt;
    logic             r_rsp_valid;
    logic [N-1:0]     r_rsp_data;

    logic w_gnt;
    logic w_accept;
    logic w_xfer;
    logic w_cnt_zero;

    // With both requesters pending, the one not served last wins.
    assign w_gnt      = (&bus.req_valid) ? ~r_last_gnt : bus.req_valid[1];
    assign w_accept   = (r_state == S_IDLE) && (|bus.req_valid) && !flush;
    assign w_xfer     = (r_state == S_DONE) && r_rsp_valid && bus.rsp_ready;
    assign w_cnt_zero = (r_cnt == '0);

    assign busy          = (r_state != S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_id;

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = 2'b00;
        lfsr_r        = 1'b1;
        lfsr_s        = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    // Kept low while reset is asserted so no grant is advertised.
                    if (reset) bus.req_ready = w_gnt ? 2'b10 : 2'b01;
                end
            end
            S_LOAD: begin
                lfsr_s      = {{(N-4){1'b0}}, r_seed};
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                lfsr_r = 1'b0;
                if (w_cnt_zero) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_xfer) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seed      <= '0;
            r_id        <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Steps go straight into the counter; LOAD leaves it untouched.
            if (w_accept) begin
                r_seed     <= w_gnt ? bus.req1_seed  : bus.req0_seed;
                r_cnt      <= w_gnt ? bus.req1_steps : bus.req0_steps;
                r_id       <= w_gnt;
                r_last_gnt <= w_gnt;
            end
            if ((r_state == S_RUN) && !flush) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end else begin
                    r_rsp_data  <= lfsr_q;
                    r_rsp_valid <= 1'b1;
                end
            end
            if (w_xfer || flush) r_rsp_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter N, default 26, SHALL set the LFSR width driven and sampled by the block.
REQ-002 Parameter CNT_W, default 8, SHALL set the step-count width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be a synchronous abort: the active transaction is dropped.
REQ-006 req_valid  input  2  SHALL be the per-requester request-valid bits.
REQ-007 req_ready  output  2  SHALL be the per-requester accept bits.
REQ-008 req0_seed, req1_seed  input  4 each  SHALL be the requester seeds.
REQ-009 req0_steps, req1_steps  input  CNT_W each  SHALL be the requester LFSR advance counts.
REQ-010 lfsr_s  output  N  SHALL be the LFSR set vector.
REQ-011 lfsr_r  output  1  SHALL be the LFSR reset bit, applied to all flip-flops.
REQ-012 lfsr_q  input  N  SHALL be the LFSR state.
REQ-013 rsp_valid  output  1  SHALL be the response-valid bit.
REQ-014 rsp_ready  input  1  SHALL be the response-ready bit.
REQ-015 rsp_id  output  1  SHALL be the requester index that owns the response.
REQ-016 rsp_data  output  N  SHALL be the captured LFSR state.
REQ-017 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-018 The block SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-019 In IDLE and DONE, outputs SHALL be lfsr_r=1 and lfsr_s=0; this parks the LFSR at zero.
REQ-020 In LOAD, outputs SHALL be lfsr_r=1 and lfsr_s={N-4 zeros, latched seed}; lfsr_q equals the seed after that edge.
REQ-021 In RUN, outputs SHALL be lfsr_r=0 and lfsr_s=0; the LFSR advances one step per clock.
REQ-022 Arbitration (IDLE only):
- single valid: grant it;
- both valid: grant the index != last_gnt;
- req_ready[g]=1 only for the granted g, combinationally; all req_ready=0 outside IDLE.
REQ-023 On an accept edge, the block SHALL latch seed, steps and id, set last_gnt=g, and go to LOAD.
REQ-024 LOAD SHALL last exactly one cycle and then go to RUN with cnt=latched steps.
REQ-025 Each RUN cycle:
- cnt!=0: cnt decrements;
- cnt==0: rsp_data<=lfsr_q, rsp_valid<=1, go to DONE.
REQ-026 The captured value SHALL be the seed advanced exactly "steps" times.
REQ-027 steps=0 SHALL capture the seed itself.
REQ-028 steps=2^CNT_W-1 SHALL complete without wrap of cnt.
REQ-029 Latency from accept edge to rsp_valid high SHALL be steps+2 cycles.
REQ-030 rsp_valid, rsp_data and rsp_id SHALL hold stable in DONE until rsp_valid&&rsp_ready.
REQ-031 On the response-transfer edge, the block SHALL clear rsp_valid and go to IDLE; a new accept becomes possible on the following cycle.
REQ-032 flush=1 in any state SHALL force the next state to IDLE and rsp_valid to 0, and SHALL leave last_gnt unchanged.
REQ-033 flush SHALL override a same-cycle response transfer; no accept SHALL occur while flush=1.
REQ-034 req_valid deasserting while not granted SHALL have no effect.
REQ-035 Requesters SHALL hold seed and steps stable only until their accept cycle.

Reset
REQ-036 reset low SHALL asynchronously force:
- state=IDLE, cnt=0, last_gnt=1;
- rsp_valid=0, rsp_data=0, rsp_id=0, busy=0;
- req_ready=0, lfsr_r=1, lfsr_s=0.
REQ-037 reset low mid-transaction SHALL discard the transaction and emit no response.
REQ-038 The first grant after reset with both requesters valid SHALL go to requester 0.

Verification (bench instantiates the team LFSR, N=26)
REQ-039 req0 seed=4'b0001, steps=3, rsp_ready=1 -> rsp_valid 5 cycles after accept, rsp_data=26'h0000008, rsp_id=0.
REQ-040 req1 seed=4'b0001, steps=0 -> rsp_data=26'h0000001 after 2 cycles, rsp_id=1.
REQ-041 Both valid continuously for 4 transactions -> rsp_id sequence 0,1,0,1.
REQ-042 rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout.
REQ-043 flush pulsed in RUN with steps=20 -> IDLE next cycle, rsp_valid never asserted, lfsr_r=1.
REQ-044 reset low for 1 cycle mid-RUN -> all outputs at reset values immediately; the next grant goes to requester 0.
